// File: rtl/video_capture_writer.sv
// Captures a windowed pixel stream into a ring of line buffers in dual-port RAM.
// Fires starttrigger once enough lines are buffered for the read side to start.
module video_capture_writer #(
    parameter int COLOR_BITS   = 8,
    parameter int COUNTER_BITS = 12,
    parameter int LINE_LENGTH  = 640,
    parameter int BUFFER_LINES = 16,
    parameter int ADDR_BITS    = 14,
    parameter int TRIGGER_ADDR = 5120,
    parameter int FIELD1_END   = 240,
    parameter int FIELD2_START = 262,
    parameter int DEF_H_START  = 0,
    parameter int DEF_H_END    = 640,
    parameter int DEF_V_START  = 0,
    parameter int DEF_V_END    = 480
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [COLOR_BITS-1:0]     R,
    input  logic [COLOR_BITS-1:0]     G,
    input  logic [COLOR_BITS-1:0]     B,
    input  logic [COUNTER_BITS-1:0]   counterX,
    input  logic [COUNTER_BITS-1:0]   counterY,
    input  logic                      line_doubler,
    input  logic [COUNTER_BITS-1:0]   cfg_h_start,
    input  logic [COUNTER_BITS-1:0]   cfg_h_end,
    input  logic [COUNTER_BITS-1:0]   cfg_v_start,
    input  logic [COUNTER_BITS-1:0]   cfg_v_end,
    output logic [3*COLOR_BITS-1:0]   wrdata,
    output logic [ADDR_BITS-1:0]      wraddr,
    output logic                      wren,
    output logic                      wrclock,
    output logic                      starttrigger,
    output logic                      line_done,
    output logic [COUNTER_BITS-1:0]   line_index
);

    localparam int RAM_NUMWORDS = LINE_LENGTH * BUFFER_LINES;

    localparam logic [COUNTER_BITS-1:0] F1_END   = COUNTER_BITS'(FIELD1_END);
    localparam logic [COUNTER_BITS-1:0] F2_START = COUNTER_BITS'(FIELD2_START);
    localparam logic [COUNTER_BITS-1:0] D_HS     = COUNTER_BITS'(DEF_H_START);
    localparam logic [COUNTER_BITS-1:0] D_HE     = COUNTER_BITS'(DEF_H_END);
    localparam logic [COUNTER_BITS-1:0] D_VS     = COUNTER_BITS'(DEF_V_START);
    localparam logic [COUNTER_BITS-1:0] D_VE     = COUNTER_BITS'(DEF_V_END);
    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_ONE  = COUNTER_BITS'(1);
    localparam logic [ADDR_BITS-1:0]    TRIG     = ADDR_BITS'(TRIGGER_ADDR);
    localparam logic [ADDR_BITS-1:0]    STEP     = ADDR_BITS'(LINE_LENGTH);

    logic [COUNTER_BITS-1:0] hs_q, he_q, vs_q, ve_q;
    logic [COUNTER_BITS-1:0] hs, he, vs, ve;
    logic [COUNTER_BITS-1:0] lines_q;
    logic [COUNTER_BITS-1:0] x_off;
    logic [ADDR_BITS-1:0]    base_q;
    logic [ADDR_BITS-1:0]    base_next;
    logic [ADDR_BITS-1:0]    addr_c;
    logic                    origin;
    logic                    degen;
    logic                    v_cap;
    logic                    h_cap;
    logic                    capture;
    logic                    line_end;
    logic                    trig_hit;

    assign wrclock = clock;

    // The frame origin pixel already belongs to the new frame, so it sees the
    // window being latched on that same cycle.
    always_comb begin
        origin = (counterX == '0) && (counterY == '0);
        hs = origin ? cfg_h_start : hs_q;
        he = origin ? cfg_h_end   : he_q;
        vs = origin ? cfg_v_start : vs_q;
        ve = origin ? cfg_v_end   : ve_q;

        degen = (he <= hs) || (ve <= vs);

        if (line_doubler) begin
            v_cap = (counterY < F1_END) ||
                    ((counterY > F2_START) && (counterY < ve));
        end else begin
            v_cap = (counterY >= vs) && (counterY < ve);
        end

        x_off = counterX - hs;
        h_cap = (counterX >= hs) && (counterX < he) &&
                (32'(x_off) < 32'(LINE_LENGTH));

        capture  = v_cap && h_cap && !degen;
        line_end = (counterX == he);
        addr_c   = base_q + ADDR_BITS'(x_off);
        trig_hit = (addr_c == TRIG) &&
                   (32'(lines_q) < 32'(BUFFER_LINES));

        if (32'(base_q) + 32'(LINE_LENGTH) >= 32'(RAM_NUMWORDS)) begin
            base_next = '0;
        end else begin
            base_next = base_q + STEP;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_q         <= D_HS;
            he_q         <= D_HE;
            vs_q         <= D_VS;
            ve_q         <= D_VE;
            base_q       <= '0;
            lines_q      <= '0;
            wren         <= 1'b0;
            wraddr       <= '0;
            wrdata       <= '0;
            starttrigger <= 1'b0;
            line_done    <= 1'b0;
            line_index   <= '0;
        end else begin
            if (origin) begin
                hs_q <= cfg_h_start;
                he_q <= cfg_h_end;
                vs_q <= cfg_v_start;
                ve_q <= cfg_v_end;
            end

            wren         <= capture;
            starttrigger <= capture && trig_hit;
            line_done    <= 1'b0;

            if (capture) begin
                wraddr <= addr_c;
                wrdata <= {R, G, B};
            end

            if (line_end) begin
                if (v_cap && !degen) begin
                    base_q     <= base_next;
                    lines_q    <= (lines_q == CNT_MAX) ? CNT_MAX : lines_q + CNT_ONE;
                    line_done  <= 1'b1;
                    line_index <= lines_q;
                end else begin
                    base_q  <= '0;
                    lines_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_capture_writer.sv
// Randomised bench for video_capture_writer on a shrunken raster and ring,
// checked every cycle against a slot-counting reference model.
module tb_video_capture_writer;

    localparam int CB      = 8;
    localparam int LL      = 16;
    localparam int BL      = 4;
    localparam int AB      = 6;
    localparam int TRIG    = 32;
    localparam int F1      = 6;
    localparam int F2      = 10;
    localparam int D_HS    = 0;
    localparam int D_HE    = 16;
    localparam int D_VS    = 0;
    localparam int D_VE    = 12;
    localparam int H_TOTAL = 40;
    localparam int V_TOTAL = 22;
    localparam int CMAX    = 255;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    R = '0, G = '0, B = '0;
    logic [CB-1:0] counterX = '0, counterY = '0;
    logic          line_doubler = 1'b0;
    logic [CB-1:0] cfg_h_start = CB'(D_HS);
    logic [CB-1:0] cfg_h_end   = CB'(D_HE);
    logic [CB-1:0] cfg_v_start = CB'(D_VS);
    logic [CB-1:0] cfg_v_end   = CB'(D_VE);
    logic [23:0]   wrdata;
    logic [AB-1:0] wraddr;
    logic          wren, wrclock, starttrigger, line_done;
    logic [CB-1:0] line_index;

    video_capture_writer #(
        .COLOR_BITS(8), .COUNTER_BITS(CB), .LINE_LENGTH(LL),
        .BUFFER_LINES(BL), .ADDR_BITS(AB), .TRIGGER_ADDR(TRIG),
        .FIELD1_END(F1), .FIELD2_START(F2),
        .DEF_H_START(D_HS), .DEF_H_END(D_HE),
        .DEF_V_START(D_VS), .DEF_V_END(D_VE)
    ) dut (
        .clock(clock), .reset(reset),
        .R(R), .G(G), .B(B),
        .counterX(counterX), .counterY(counterY),
        .line_doubler(line_doubler),
        .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
        .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end),
        .wrdata(wrdata), .wraddr(wraddr), .wren(wren),
        .wrclock(wrclock), .starttrigger(starttrigger),
        .line_done(line_done), .line_index(line_index)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // model state: window in force, lines captured since the chain restarted
    int sh_hs, sh_he, sh_vs, sh_ve;
    int m_chain;
    bit e_wren, e_trig, e_ld;
    int e_addr, e_idx;
    logic [23:0] e_data;

    int cur_x, cur_y;
    int f_wr, f_trig, f_ld;
    bit force_rgb, lat_check, watch_first;
    bit pend_on;
    int pend_x, pend_y, p_hs, p_he, p_vs, p_ve;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)",
                     name, act, exp, cur_x, cur_y, $time);
        end
    endtask

    task automatic model_reset();
        sh_hs = D_HS; sh_he = D_HE; sh_vs = D_VS; sh_ve = D_VE;
        m_chain = 0;
        e_wren = 0; e_trig = 0; e_ld = 0;
        e_addr = 0; e_idx = 0; e_data = '0;
    endtask

    task automatic model_step(input int x, input int y);
        bit degen, vc, hc;
        if (x == 0 && y == 0) begin
            sh_hs = int'(cfg_h_start); sh_he = int'(cfg_h_end);
            sh_vs = int'(cfg_v_start); sh_ve = int'(cfg_v_end);
        end
        degen = !(sh_he > sh_hs) || !(sh_ve > sh_vs);
        if (line_doubler)
            vc = (y < F1) || (y > F2 && y < sh_ve);
        else
            vc = (y >= sh_vs) && (y < sh_ve);
        hc = (x >= sh_hs) && (x < sh_he) && (x - sh_hs < LL);
        e_wren = vc && hc && !degen;
        e_trig = 0;
        e_ld   = 0;
        if (e_wren) begin
            e_addr = (m_chain % BL) * LL + (x - sh_hs);
            e_data = {R, G, B};
            e_trig = (e_addr == TRIG) && (m_chain < BL);
        end
        if (x == sh_he) begin
            if (vc && !degen) begin
                e_ld  = 1;
                e_idx = (m_chain > CMAX) ? CMAX : m_chain;
                m_chain++;
            end else begin
                m_chain = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("wren", 32'(wren), 32'(e_wren));
        chk("starttrigger", 32'(starttrigger), 32'(e_trig));
        chk("line_done", 32'(line_done), 32'(e_ld));
        chk("wraddr", 32'(wraddr), 32'(e_addr));
        chk("wrdata", 32'(wrdata), 32'(e_data));
        chk("wrclock", 32'(wrclock), 32'd1);
        if (e_ld) chk("line_index", 32'(line_index), 32'(e_idx));
    endtask

    task automatic tick(input int x, input int y);
        cur_x = x; cur_y = y;
        if (pend_on && x == pend_x && y == pend_y) begin
            cfg_h_start = CB'(p_hs); cfg_h_end = CB'(p_he);
            cfg_v_start = CB'(p_vs); cfg_v_end = CB'(p_ve);
            pend_on = 0;
        end
        counterX = CB'(x);
        counterY = CB'(y);
        if (force_rgb) begin
            R = 8'hAA; G = 8'h55; B = 8'h11;
            force_rgb = 0;
        end else begin
            R = 8'($urandom); G = 8'($urandom); B = 8'($urandom);
        end
        @(posedge clock);
        #1;
        if (reset) model_reset();
        else model_step(x, y);
        compare_all();
        f_wr   += int'(wren);
        f_trig += int'(starttrigger);
        f_ld   += int'(line_done);
        if (watch_first && wren) begin
            chk("first_wr_after_reset", 32'(wraddr), 32'd12);
            watch_first = 0;
        end
    endtask

    task automatic set_pending(input int y, input int x, input int hs,
                               input int he, input int vs, input int ve);
        pend_on = 1; pend_y = y; pend_x = x;
        p_hs = hs; p_he = he; p_vs = vs; p_ve = ve;
    endtask

    task automatic run_frame(input int rst_y, input int rst_x);
        bit rel;
        rel = 0;
        f_wr = 0; f_trig = 0; f_ld = 0;
        for (int y = 0; y < V_TOTAL; y++) begin
            for (int x = 0; x < H_TOTAL; x++) begin
                tick(x, y);
                if (lat_check && x == 0 && y == 0) begin
                    chk("lat_wren", 32'(wren), 32'd1);
                    chk("lat_wraddr", 32'(wraddr), 32'd0);
                    chk("lat_wrdata", 32'(wrdata), 32'hAA5511);
                    lat_check = 0;
                end
                if (rel) begin
                    #2 reset = 1'b0;
                    rel = 0;
                    watch_first = 1;
                end
                if (y == rst_y && x == rst_x) begin
                    #2 reset = 1'b1;
                    #1;
                    chk("rst_wren", 32'(wren), 32'd0);
                    chk("rst_trig", 32'(starttrigger), 32'd0);
                    chk("rst_line_done", 32'(line_done), 32'd0);
                    chk("rst_wraddr", 32'(wraddr), 32'd0);
                    rel = 1;
                end
            end
        end
    endtask

    initial begin
        pend_on = 0; force_rgb = 0; lat_check = 0; watch_first = 0;
        model_reset();
        tick(0, 0);
        tick(0, 0);
        chk("reset_wren", 32'(wren), 32'd0);
        chk("reset_wraddr", 32'(wraddr), 32'd0);
        chk("reset_wrdata", 32'(wrdata), 32'd0);
        chk("reset_trig", 32'(starttrigger), 32'd0);
        chk("reset_line_done", 32'(line_done), 32'd0);
        chk("reset_line_index", 32'(line_index), 32'd0);
        reset = 1'b0;

        // progressive defaults: 12 lines of 16, one trigger
        force_rgb = 1; lat_check = 1;
        run_frame(-1, -1);
        chk("A_writes", 32'(f_wr), 32'd192);
        chk("A_trig", 32'(f_trig), 32'd1);
        chk("A_line_done", 32'(f_ld), 32'd12);

        // field mode: lines 0..5 and 11..17, chain restarts after the gap
        line_doubler = 1'b1;
        cfg_v_end = CB'(18);
        run_frame(-1, -1);
        chk("B_writes", 32'(f_wr), 32'd208);
        chk("B_trig", 32'(f_trig), 32'd2);
        chk("B_line_done", 32'(f_ld), 32'd13);

        // mid-frame window change only applies next frame
        line_doubler = 1'b0;
        cfg_v_end = CB'(D_VE);
        set_pending(5, 0, 4, 36, 2, 7);
        run_frame(-1, -1);
        chk("C_writes", 32'(f_wr), 32'd192);
        chk("C_trig", 32'(f_trig), 32'd1);
        set_pending(10, 0, D_HS, D_HE, D_VS, D_VE);
        run_frame(-1, -1);
        chk("D_writes", 32'(f_wr), 32'd80);
        chk("D_line_done", 32'(f_ld), 32'd5);
        chk("D_trig", 32'(f_trig), 32'd1);

        // async reset mid-line, then degenerate window next frame
        set_pending(15, 0, 5, 5, D_VS, D_VE);
        run_frame(5, 10);
        chk("E_first_write_seen", 32'(watch_first), 32'd0);
        run_frame(-1, -1);
        chk("F_writes", 32'(f_wr), 32'd0);
        chk("F_trig", 32'(f_trig), 32'd0);
        chk("F_line_done", 32'(f_ld), 32'd0);

        for (int i = 0; i < 20; i++) begin
            int hs, he, vs, ve;
            hs = int'($urandom_range(0, 30));
            he = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40))
                                             : hs + int'($urandom_range(1, 26));
            vs = int'($urandom_range(0, 15));
            ve = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 23))
                                             : vs + int'($urandom_range(1, 10));
            line_doubler = 1'($urandom_range(0, 1));
            set_pending(int'($urandom_range(0, V_TOTAL - 1)),
                        int'($urandom_range(1, H_TOTAL - 1)), hs, he, vs, ve);
            run_frame(-1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
